secded_err_logger: RTL and testbench

//  Sequential error-statistics stage directly downstream of the hamming_secded decoder.
//  - Samples the decoder's data and error flags on a valid strobe.
//  - Keeps saturating per-class error counters and sticky flags.
//  - Raises an interrupt on an uncorrectable error or a corrected-error threshold.
//  - Buffers error events in a small FIFO that software/debug drains via a valid/ready handshake.

---
 rtl/secded_log_pkg.sv | 41 ++++
 rtl/secded_evt_fifo.sv | 58 +++++
 rtl/secded_err_logger.sv | 109 ++++++++++
 tb/tb_secded_err_logger.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/secded_log_pkg.sv
// rtl/secded_log_pkg.sv - shared event codes, record layout and classifier for the SECDED error logger
package secded_log_pkg;

    localparam logic [1:0] EVT_CLEAN  = 2'b00;
    localparam logic [1:0] EVT_CORR   = 2'b01;
    localparam logic [1:0] EVT_UNCORR = 2'b10;
    localparam logic [1:0] EVT_PAR    = 2'b11;

    localparam int IDX_W    = 8;
    localparam int TYPE_W   = 2;
    localparam int DATA_W   = 4;
    localparam int EVT_W    = 14;

    localparam int DATA_LSB = 0;
    localparam int TYPE_LSB = DATA_LSB + DATA_W;
    localparam int IDX_LSB  = TYPE_LSB + TYPE_W;

    // Uncorrectable dominates corrected, which dominates parity-only.
    function automatic logic [1:0] classify(input logic e1, input logic e2, input logic ep);
        if (e2)
            return EVT_UNCORR;
        else if (e1)
            return EVT_CORR;
        else if (ep)
            return EVT_PAR;
        else
            return EVT_CLEAN;
    endfunction

    function automatic logic [EVT_W-1:0] make_evt(input logic [IDX_W-1:0] idx,
                                                  input logic [TYPE_W-1:0] typ,
                                                  input logic [DATA_W-1:0] data);
        logic [EVT_W-1:0] e;
        e = '0;
        e[IDX_LSB +: IDX_W]   = idx;
        e[TYPE_LSB +: TYPE_W] = typ;
        e[DATA_LSB +: DATA_W] = data;
        return e;
    endfunction

endpackage

// File: rtl/secded_evt_fifo.sv
// rtl/secded_evt_fifo.sv - synchronous event FIFO with occupancy counter and pop-frees-slot push
module secded_evt_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push && (!full || do_pop);
    // Head reads as zero when empty so reset/idle never exposes stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/secded_err_logger.sv
// rtl/secded_err_logger.sv - SECDED error statistics: counters, sticky flags, irq and event FIFO
module secded_err_logger
    import secded_log_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int THRESH     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [3:0]       i_data,
    input  logic             i_1bit_error,
    input  logic             i_2bit_error,
    input  logic             i_parity_error,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt_1bit,
    output logic [CNT_W-1:0] o_cnt_2bit,
    output logic [CNT_W-1:0] o_cnt_parity,
    output logic [2:0]       o_sticky,
    output logic             o_irq,
    output logic             o_overflow,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [EVT_W-1:0] o_evt_data
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    logic [1:0]       evt_type;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_1bit_nxt;
    logic [CNT_W-1:0] cnt_2bit_nxt;
    logic [CNT_W-1:0] cnt_parity_nxt;
    logic [2:0]       sticky_nxt;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    // Classify the sample and form saturating next-state values for the statistics.
    always_comb begin
        evt_type       = i_valid ? classify(i_1bit_error, i_2bit_error, i_parity_error) : EVT_CLEAN;
        cnt_1bit_nxt   = o_cnt_1bit;
        cnt_2bit_nxt   = o_cnt_2bit;
        cnt_parity_nxt = o_cnt_parity;
        if (evt_type == EVT_CORR && o_cnt_1bit != CNT_MAX)
            cnt_1bit_nxt = o_cnt_1bit + 1'b1;
        if (evt_type == EVT_UNCORR && o_cnt_2bit != CNT_MAX)
            cnt_2bit_nxt = o_cnt_2bit + 1'b1;
        if (evt_type == EVT_PAR && o_cnt_parity != CNT_MAX)
            cnt_parity_nxt = o_cnt_parity + 1'b1;
        sticky_nxt = o_sticky | {evt_type == EVT_PAR, evt_type == EVT_UNCORR, evt_type == EVT_CORR};
    end

    assign push = (evt_type != EVT_CLEAN);
    // Full implies a valid head, so a ready consumer always frees a slot.
    assign drop = push && fifo_full && !i_evt_ready;
    assign o_evt_valid = !fifo_empty;

    // Sample index counts every valid strobe and is deliberately untouched by i_clr.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            idx <= '0;
        else if (i_valid)
            idx <= idx + 1'b1;
    end

    // Statistics registers; clear overrides any update arriving the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt_1bit   <= '0;
            o_cnt_2bit   <= '0;
            o_cnt_parity <= '0;
            o_sticky     <= '0;
            o_irq        <= 1'b0;
            o_overflow   <= 1'b0;
        end else if (i_clr) begin
            o_cnt_1bit   <= '0;
            o_cnt_2bit   <= '0;
            o_cnt_parity <= '0;
            o_sticky     <= '0;
            o_irq        <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_cnt_1bit   <= cnt_1bit_nxt;
            o_cnt_2bit   <= cnt_2bit_nxt;
            o_cnt_parity <= cnt_parity_nxt;
            o_sticky     <= sticky_nxt;
            o_irq        <= o_irq || sticky_nxt[1] || (cnt_1bit_nxt >= THRESH_V);
            o_overflow   <= o_overflow || drop;
        end
    end

    secded_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (make_evt(idx, evt_type, i_data)),
        .pop       (i_evt_ready),
        .pop_data  (o_evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_secded_err_logger.sv
// tb/tb_secded_err_logger.sv - scoreboard bench for secded_err_logger (CNT_W=8 and CNT_W=2 instances)
module tb_secded_err_logger;

    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [3:0] i_data = '0;
    logic       i_1bit_error = 1'b0;
    logic       i_2bit_error = 1'b0;
    logic       i_parity_error = 1'b0;
    logic       i_clr = 1'b0;
    logic       i_evt_ready = 1'b0;

    logic [7:0]  a_c1, a_c2, a_cp;
    logic [1:0]  b_c1, b_c2, b_cp;
    logic [2:0]  a_st, b_st;
    logic        a_irq, b_irq, a_ovf, b_ovf, a_ev, b_ev;
    logic [13:0] a_ed, b_ed;

    always #5 i_clk = ~i_clk;

    secded_err_logger #(.CNT_W(8), .FIFO_DEPTH(DEPTH), .THRESH(4)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_1bit_error(i_1bit_error), .i_2bit_error(i_2bit_error), .i_parity_error(i_parity_error),
        .i_clr(i_clr), .o_cnt_1bit(a_c1), .o_cnt_2bit(a_c2), .o_cnt_parity(a_cp),
        .o_sticky(a_st), .o_irq(a_irq), .o_overflow(a_ovf), .o_evt_valid(a_ev),
        .i_evt_ready(i_evt_ready), .o_evt_data(a_ed)
    );

    secded_err_logger #(.CNT_W(2), .FIFO_DEPTH(DEPTH), .THRESH(3)) u_dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_1bit_error(i_1bit_error), .i_2bit_error(i_2bit_error), .i_parity_error(i_parity_error),
        .i_clr(i_clr), .o_cnt_1bit(b_c1), .o_cnt_2bit(b_c2), .o_cnt_parity(b_cp),
        .o_sticky(b_st), .o_irq(b_irq), .o_overflow(b_ovf), .o_evt_valid(b_ev),
        .i_evt_ready(i_evt_ready), .o_evt_data(b_ed)
    );

    // Observed outputs of whichever instance the model currently tracks.
    logic        sel = 1'b0;
    logic [7:0]  o_c1, o_c2, o_cp;
    logic [2:0]  o_st;
    logic        o_irq, o_ovf, o_ev;
    logic [13:0] o_ed;
    always_comb begin
        o_c1  = sel ? {6'd0, b_c1} : a_c1;
        o_c2  = sel ? {6'd0, b_c2} : a_c2;
        o_cp  = sel ? {6'd0, b_cp} : a_cp;
        o_st  = sel ? b_st  : a_st;
        o_irq = sel ? b_irq : a_irq;
        o_ovf = sel ? b_ovf : a_ovf;
        o_ev  = sel ? b_ev  : a_ev;
        o_ed  = sel ? b_ed  : a_ed;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          m_max = 255;
    int          m_thr = 4;
    int          m_c1, m_c2, m_cp;
    logic [2:0]  m_st;
    logic        m_irq, m_ovf;
    logic [7:0]  m_idx;
    logic [13:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c1 = 0; m_c2 = 0; m_cp = 0;
        m_st = '0; m_irq = 1'b0; m_ovf = 1'b0; m_idx = '0;
        exp_q.delete();
    endtask

    task automatic check_all();
        check("cnt_1bit", 32'(o_c1), 32'(m_c1));
        check("cnt_2bit", 32'(o_c2), 32'(m_c2));
        check("cnt_parity", 32'(o_cp), 32'(m_cp));
        check("sticky", 32'(o_st), 32'(m_st));
        check("irq", 32'(o_irq), 32'(m_irq));
        check("overflow", 32'(o_ovf), 32'(m_ovf));
        check("evt_valid", 32'(o_ev), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0)
            check("evt_head", 32'(o_ed), 32'(exp_q[0]));
    endtask

    task automatic check_reset_state();
        check("rst_cnt_1bit", 32'(o_c1), 32'd0);
        check("rst_cnt_2bit", 32'(o_c2), 32'd0);
        check("rst_cnt_parity", 32'(o_cp), 32'd0);
        check("rst_sticky", 32'(o_st), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_overflow", 32'(o_ovf), 32'd0);
        check("rst_evt_valid", 32'(o_ev), 32'd0);
        check("rst_evt_data", 32'(o_ed), 32'd0);
    endtask

    // One clock of stimulus, starting and ending on a falling edge.
    task automatic cycle(input logic v, input logic [3:0] d, input logic e1, input logic e2,
                         input logic ep, input logic clr, input logic rdy);
        logic [1:0] t;
        logic       pop;
        logic       acc;
        i_valid = v; i_data = d; i_1bit_error = e1; i_2bit_error = e2;
        i_parity_error = ep; i_clr = clr; i_evt_ready = rdy;
        t = 2'b00;
        if (v) begin
            if (e2)      t = 2'b10;
            else if (e1) t = 2'b01;
            else if (ep) t = 2'b11;
        end
        pop = rdy && (exp_q.size() > 0);
        acc = (exp_q.size() < DEPTH) || pop;
        if (pop)
            void'(exp_q.pop_front());
        if (t != 2'b00 && acc)
            exp_q.push_back({m_idx, t, d});
        if (clr) begin
            m_c1 = 0; m_c2 = 0; m_cp = 0; m_st = '0; m_irq = 1'b0; m_ovf = 1'b0;
        end else begin
            if (t == 2'b01 && m_c1 < m_max) m_c1++;
            if (t == 2'b10 && m_c2 < m_max) m_c2++;
            if (t == 2'b11 && m_cp < m_max) m_cp++;
            if (t == 2'b01) m_st[0] = 1'b1;
            if (t == 2'b10) m_st[1] = 1'b1;
            if (t == 2'b11) m_st[2] = 1'b1;
            if (t == 2'b10 || m_c1 >= m_thr) m_irq = 1'b1;
            if (t != 2'b00 && !acc) m_ovf = 1'b1;
        end
        if (v) m_idx = m_idx + 8'd1;
        @(negedge i_clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge i_clk);
        check_reset_state();
        i_rst = 1'b0;
        @(negedge i_clk);

        // 16 clean words, then a parity error whose record must carry idx 16.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idx16_record", 32'(o_ed), 32'({8'd16, 2'b11, 4'h7}));
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        i_rst = 1'b1;
        model_reset();
        @(negedge i_clk);
        check_reset_state();
        i_rst = 1'b0;

        // Four corrected errors with consumer stalled; irq on the fourth.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 4'(i + 3), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("irq_at_thresh", 32'(o_irq), 32'd1);
        // Fifth while full is dropped, then pop+push in the same cycle is accepted.
        cycle(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("overflow_set", 32'(o_ovf), 32'd1);
        cycle(1'b1, 4'hb, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("occupancy_4", 32'(exp_q.size()), 32'd4);
        // Holding ready low keeps the head stable.
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Uncorrectable with data 1010 (1-bit flag also raised to exercise priority).
        cycle(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("uncorr_record", 32'(o_ed), 32'({m_idx - 8'd1, 2'b10, 4'b1010}));
        // Parity-only, then clear colliding with a corrected error.
        cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'hc, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_irq", 32'(o_irq), 32'd0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Narrow counter instance: saturation at 3.
        i_rst = 1'b1;
        @(negedge i_clk);
        sel = 1'b1; m_max = 3; m_thr = 3;
        model_reset();
        #1;
        check_reset_state();
        i_rst = 1'b0;
        @(negedge i_clk);
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, (i % 3) == 0);
        check("sat_cnt_1bit", 32'(o_c1), 32'd3);

        // Asynchronous reset mid-stream, away from any clock edge.
        i_valid = 1'b1; i_1bit_error = 1'b1; i_evt_ready = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check_reset_state();
        @(negedge i_clk);
        i_rst = 1'b0;
        i_valid = 1'b0; i_1bit_error = 1'b0;
        @(negedge i_clk);
        check_reset_state();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
